cc1200_apb_cfg_sequencer: RTL
=============================

Name: cc1200_apb_cfg_sequencer

Overview:
- Autonomous APB master that replays a register-write table into the two CC1200 SPI controller instances (Tx path and Rx path).
- Each table entry targets Tx, Rx or both. Dual-target entries are issued to both slaves in the same APB transfer.
- Replaces hand-sequenced CPU writes (config registers 0x14/0x24/0x28, then mode register 0x00) at bring-up.
- Sits between the table source (ROM or register file) and the shared APB bus of both SPI tops.

Parameters:
- NUM_ENTRIES, 8: maximum table length. Minimum 1, maximum 16.
- IDX_W, 4: width of tbl_idx. Must satisfy 2^IDX_W >= NUM_ENTRIES.
- TIMEOUT, 32: maximum ACCESS cycles allowed per entry before an error.

Ports:
- clk, input, 1: clock (APB clock domain).
- rstn, input, 1: reset, asynchronous, active-high. Despite its name, rstn=1 resets the block.
- start, input, 1: single-cycle pulse; starts a sequence from entry 0.
- abort, input, 1: forces a return to IDLE.
- tbl_idx, output, IDX_W: index of the entry being fetched.
- tbl_addr, input, 32: register address of entry tbl_idx (combinational lookup).
- tbl_data, input, 32: write data of entry tbl_idx.
- tbl_tgt, input, 2: target select. bit0 = Tx, bit1 = Rx; 00 = skip entry.
- tbl_last, input, 1: marks the final entry.
- paddr, output, 32: APB address.
- pwdata, output, 32: APB write data.
- pwrite, output, 1: APB write strobe.
- penable, output, 1: APB enable.
- psel_tx, output, 1: APB select for the Tx SPI top.
- psel_rx, output, 1: APB select for the Rx SPI top.
- pready_tx, input, 1: APB ready from the Tx SPI top.
- pready_rx, input, 1: APB ready from the Rx SPI top.
- pslverr_tx, input, 1: APB slave error from the Tx SPI top.
- pslverr_rx, input, 1: APB slave error from the Rx SPI top.
- busy, output, 1: high in every state except IDLE.
- done, output, 1: one-cycle pulse on successful completion.
- err, output, 1: sticky error flag.
- err_code, output, 2: 01 = slave error, 10 = timeout.
- err_idx, output, IDX_W: index of the failing entry.

Behaviour:
- Reset values: all outputs 0; state IDLE; internal counters 0.
- All outputs are registered.
- States: IDLE, FETCH, SETUP, ACCESS, NEXT, DONE, ERROR.
- IDLE:
  - start=1 -> FETCH; tbl_idx<=0; err, err_code, err_idx cleared.
  - start while busy is ignored.
- FETCH (1 cycle):
  - Latch tbl_addr, tbl_data, tbl_tgt and tbl_last into internal registers.
  - If tbl_tgt==00 -> NEXT; otherwise -> SETUP.
- SETUP (1 cycle):
  - paddr and pwdata take the latched values; pwrite=1.
  - psel_tx = tgt[0]; psel_rx = tgt[1]; penable=0.
  - Clear pending flags pend_tx = tgt[0], pend_rx = tgt[1].
  - Clear the timeout counter.
- ACCESS:
  - penable=1; the timeout counter increments every cycle.
  - Each cycle, for each pending slave whose pready=1:
    - if its pslverr=1 -> ERROR with err_code=01;
    - otherwise clear its pend flag, and deassert its psel at the next edge.
  - penable stays high while any slave is pending.
  - Both pend flags clear -> NEXT; psel_tx, psel_rx, penable and pwrite all drop to 0 at that edge.
  - Counter reaches TIMEOUT-1 with any slave still pending -> ERROR with err_code=10.
  - Simultaneous pready and timeout on the same cycle: pready wins.
- NEXT:
  - latched tbl_last=1, or tbl_idx==NUM_ENTRIES-1 -> DONE.
  - Otherwise tbl_idx<=tbl_idx+1 -> FETCH. tbl_idx never wraps.
- DONE: done=1 for one cycle -> IDLE.
- ERROR (1 cycle):
  - err<=1; err_idx<=tbl_idx.
  - All APB outputs <=0 -> IDLE.
  - err stays high until the next accepted start or reset.
- abort:
  - In any non-IDLE state, forces IDLE at the next edge and clears every APB output in that edge.
  - No done pulse; err is left unchanged.
  - abort beats start when both arrive in the same cycle.
  - abort during ACCESS truncates the APB transfer; this is accepted, and the integrator must re-run the sequence afterwards.
- Reset mid-sequence: immediate asynchronous return to IDLE with all outputs 0.
- Latency per entry with zero-wait slaves: FETCH + SETUP + 1 ACCESS + NEXT = 4 cycles. The full table adds one DONE cycle.

Test Plan:
1. Table {0x14:0x4 tgt=11, 0x24:0x10 tgt=11, 0x28:0x10 tgt=11, 0x00:0x4 tgt=10, 0x00:0x2 tgt=01 last}, zero-wait slaves -> Tx receives writes 0x14, 0x24, 0x28, then 0x00=0x2; Rx receives 0x14, 0x24, 0x28, then 0x00=0x4; done pulses once after 21 cycles; err=0.
2. Dual-target entry, pready_tx at ACCESS cycle 1 and pready_rx at cycle 3 -> psel_tx drops after cycle 1, psel_rx held until cycle 3, exactly one write reaches each slave, then NEXT.
3. pready_rx held 0 with TIMEOUT=32 on entry 2 -> ERROR after 32 ACCESS cycles; err=1, err_code=10, err_idx=2; no done; all APB outputs 0.
4. pslverr_tx=1 together with pready_tx on entry 1 -> err_code=01, err_idx=1; entries 2 onward never issued.
5. abort asserted in ACCESS of entry 3, and start+abort in the same IDLE cycle -> IDLE next edge with APB outputs 0 and no done; the same-cycle start is ignored.
6. Entry with tgt=00, a full 8-entry table with no last flag, and rstn pulsed mid-ACCESS -> skipped entry produces no psel; sequence stops after tbl_idx=7; reset immediately zeroes every output.

Source files
------------

// File: rtl/cc1200_apb_cfg_sequencer.sv
// cc1200_apb_cfg_sequencer: replays a register-write table onto the Tx/Rx CC1200 SPI APB slaves
module cc1200_apb_cfg_sequencer #(
  parameter int NUM_ENTRIES = 8,
  parameter int IDX_W = 4,
  parameter int TIMEOUT = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             abort,
  output logic [IDX_W-1:0] tbl_idx,
  input  logic [31:0]      tbl_addr,
  input  logic [31:0]      tbl_data,
  input  logic [1:0]       tbl_tgt,
  input  logic             tbl_last,
  output logic [31:0]      paddr,
  output logic [31:0]      pwdata,
  output logic             pwrite,
  output logic             penable,
  output logic             psel_tx,
  output logic             psel_rx,
  input  logic             pready_tx,
  input  logic             pready_rx,
  input  logic             pslverr_tx,
  input  logic             pslverr_rx,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [1:0]       err_code,
  output logic [IDX_W-1:0] err_idx
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, FETCH, SETUP, ACCESS, NEXT, DONE, ERROR} stateT;
  stateT state;
  logic lastQ, pendTx, pendRx;
  logic [CW-1:0] cnt;
  logic okTx, okRx, slvErr, remain, timeUp;
  assign okTx = pendTx & pready_tx & ~pslverr_tx;
  assign okRx = pendRx & pready_rx & ~pslverr_rx;
  assign slvErr = (pendTx & pready_tx & pslverr_tx) | (pendRx & pready_rx & pslverr_rx);
  assign remain = (pendTx & ~okTx) | (pendRx & ~okRx);
  assign timeUp = cnt == CW'(TIMEOUT - 1);
  // Outputs are assigned on the edge entering the state in which they must be visible.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state <= IDLE;
      tbl_idx <= '0;
      paddr <= '0;
      pwdata <= '0;
      pwrite <= 1'b0;
      penable <= 1'b0;
      psel_tx <= 1'b0;
      psel_rx <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      err_code <= 2'b00;
      err_idx <= '0;
      lastQ <= 1'b0;
      pendTx <= 1'b0;
      pendRx <= 1'b0;
      cnt <= '0;
    end else if (abort && state != IDLE) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      paddr <= '0;
      pwdata <= '0;
      pwrite <= 1'b0;
      penable <= 1'b0;
      psel_tx <= 1'b0;
      psel_rx <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start && !abort) begin
          state <= FETCH;
          busy <= 1'b1;
          tbl_idx <= '0;
          err <= 1'b0;
          err_code <= 2'b00;
          err_idx <= '0;
        end
        FETCH: begin
          lastQ <= tbl_last;
          paddr <= tbl_addr;
          pwdata <= tbl_data;
          pwrite <= tbl_tgt != 2'b00;
          psel_tx <= tbl_tgt[0];
          psel_rx <= tbl_tgt[1];
          pendTx <= tbl_tgt[0];
          pendRx <= tbl_tgt[1];
          state <= tbl_tgt == 2'b00 ? NEXT : SETUP;
        end
        SETUP: begin
          penable <= 1'b1;
          cnt <= '0;
          state <= ACCESS;
        end
        ACCESS: begin
          cnt <= cnt + 1'b1;
          pendTx <= pendTx & ~okTx;
          pendRx <= pendRx & ~okRx;
          psel_tx <= psel_tx & ~okTx;
          psel_rx <= psel_rx & ~okRx;
          if (slvErr || !remain || timeUp) begin
            state <= (slvErr || remain) ? ERROR : NEXT;
            err_code <= slvErr ? 2'b01 : remain ? 2'b10 : err_code;
            paddr <= '0;
            pwdata <= '0;
            pwrite <= 1'b0;
            penable <= 1'b0;
            psel_tx <= 1'b0;
            psel_rx <= 1'b0;
          end
        end
        NEXT: if (lastQ || tbl_idx == IDX_W'(NUM_ENTRIES - 1)) begin
          state <= DONE;
          done <= 1'b1;
        end else begin
          tbl_idx <= tbl_idx + 1'b1;
          state <= FETCH;
        end
        DONE: begin
          done <= 1'b0;
          busy <= 1'b0;
          state <= IDLE;
        end
        ERROR: begin
          err <= 1'b1;
          err_idx <= tbl_idx;
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
